serial_word_receiver: RTL and testbench

SERIAL_WORD_RECEIVER -- requirements
Module: serial_word_receiver

---
 rtl/serial_word_receiver.sv | 162 ++++++++++++++++
 tb/tb_serial_word_receiver.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_receiver.sv
// Bit-serial to parallel receiver with every control/data field held in three voted copies.
// Word visible one cycle after its last bit; held until out_ready, input arriving meanwhile is dropped and sets overrun.
module serial_word_receiver #(
    parameter int width = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             start,
    input  logic             bit_valid,
    input  logic             serial_in,
    input  logic             msb_first,
    input  logic             out_ready,
    output logic [width-1:0] parallel_out,
    output logic             out_valid,
    output logic             busy,
    output logic             overrun,
    output logic             frame_abort,
    output logic             tmr_mismatch
);
    localparam int cnt_w = $clog2(width);
    localparam logic [cnt_w-1:0] cnt_last = cnt_w'(width - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        HOLD = 2'd2
    } state_t;

    logic [1:0]       state_c0, state_c1, state_c2, state_vb;
    logic [cnt_w-1:0] cnt_c0, cnt_c1, cnt_c2, cnt_v;
    logic [width-1:0] sreg_c0, sreg_c1, sreg_c2, sreg_v;
    logic             order_c0, order_c1, order_c2, order_v;
    state_t           state_v;
    logic             upset;

    assign state_vb = (state_c0 & state_c1) | (state_c0 & state_c2) | (state_c1 & state_c2);
    assign cnt_v    = (cnt_c0 & cnt_c1) | (cnt_c0 & cnt_c2) | (cnt_c1 & cnt_c2);
    assign sreg_v   = (sreg_c0 & sreg_c1) | (sreg_c0 & sreg_c2) | (sreg_c1 & sreg_c2);
    assign order_v  = (order_c0 & order_c1) | (order_c0 & order_c2) | (order_c1 & order_c2);
    assign state_v  = state_t'(state_vb);

    assign upset = (state_c0 != state_vb) | (state_c1 != state_vb) | (state_c2 != state_vb)
                 | (cnt_c0 != cnt_v) | (cnt_c1 != cnt_v) | (cnt_c2 != cnt_v)
                 | (sreg_c0 != sreg_v) | (sreg_c1 != sreg_v) | (sreg_c2 != sreg_v)
                 | (order_c0 != order_v) | (order_c1 != order_v) | (order_c2 != order_v);

    assign busy = (state_v == RECV);

    state_t           state_n;
    logic [cnt_w-1:0] cnt_n;
    logic [width-1:0] sreg_n, pout_n;
    logic             order_n, ovalid_n, ovr_n, abort_n, start_frame;

    always_comb begin
        state_n     = state_v;
        cnt_n       = cnt_v;
        sreg_n      = sreg_v;
        order_n     = order_v;
        pout_n      = parallel_out;
        ovalid_n    = out_valid;
        ovr_n       = overrun;
        abort_n     = 1'b0;
        start_frame = 1'b0;

        case (state_v)
            IDLE: start_frame = start;
            RECV: begin
                if (start) begin
                    start_frame = 1'b1;
                    abort_n     = 1'b1;
                end else if (bit_valid) begin
                    sreg_n = order_v ? {sreg_v[width-2:0], serial_in}
                                     : {serial_in, sreg_v[width-1:1]};
                    if (cnt_v == cnt_last) begin
                        pout_n   = sreg_n;
                        ovalid_n = 1'b1;
                        state_n  = HOLD;
                        cnt_n    = '0;
                    end else begin
                        cnt_n = cnt_v + cnt_w'(1);
                    end
                end
            end
            HOLD: begin
                if (out_valid && out_ready) begin
                    ovalid_n    = 1'b0;
                    state_n     = IDLE;
                    start_frame = start;
                end else if (start || bit_valid) begin
                    ovr_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        // A bit arriving with start is the first bit of the new frame.
        if (start_frame) begin
            state_n = RECV;
            order_n = msb_first;
            sreg_n  = '0;
            cnt_n   = '0;
            if (bit_valid) begin
                sreg_n = msb_first ? {{(width-1){1'b0}}, serial_in}
                                   : {serial_in, {(width-1){1'b0}}};
                cnt_n  = cnt_w'(1);
            end
        end

        // Frozen cycles still rewrite the copies from the vote, which scrubs upsets.
        if (!enable) begin
            state_n  = state_v;
            cnt_n    = cnt_v;
            sreg_n   = sreg_v;
            order_n  = order_v;
            pout_n   = parallel_out;
            ovalid_n = out_valid;
            ovr_n    = overrun;
            abort_n  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_c0     <= IDLE;
            state_c1     <= IDLE;
            state_c2     <= IDLE;
            cnt_c0       <= '0;
            cnt_c1       <= '0;
            cnt_c2       <= '0;
            sreg_c0      <= '0;
            sreg_c1      <= '0;
            sreg_c2      <= '0;
            order_c0     <= 1'b0;
            order_c1     <= 1'b0;
            order_c2     <= 1'b0;
            parallel_out <= '0;
            out_valid    <= 1'b0;
            overrun      <= 1'b0;
            frame_abort  <= 1'b0;
            tmr_mismatch <= 1'b0;
        end else begin
            state_c0     <= state_n;
            state_c1     <= state_n;
            state_c2     <= state_n;
            cnt_c0       <= cnt_n;
            cnt_c1       <= cnt_n;
            cnt_c2       <= cnt_n;
            sreg_c0      <= sreg_n;
            sreg_c1      <= sreg_n;
            sreg_c2      <= sreg_n;
            order_c0     <= order_n;
            order_c1     <= order_n;
            order_c2     <= order_n;
            parallel_out <= pout_n;
            out_valid    <= ovalid_n;
            overrun      <= ovr_n;
            frame_abort  <= abort_n;
            tmr_mismatch <= enable & upset;
        end
    end
endmodule

// File: tb/tb_serial_word_receiver.sv
// Randomized bench for serial_word_receiver: frames are queued as whole words, a monitor checks each delivered word.
module tb_serial_word_receiver;
    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst, enable, start, bit_valid, serial_in, msb_first, out_ready;
    logic [W-1:0] parallel_out;
    logic         out_valid, busy, overrun, frame_abort, tmr_mismatch;

    int           checks = 0;
    int           failures = 0;
    int           abort_seen = 0;
    int           tmr_seen = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_exp;
    logic         prev_ov = 1'b0;
    logic [W-1:0] sbad;
    logic [1:0]   stbad;

    always #5 clk = ~clk;

    serial_word_receiver #(.width(W)) dut (
        .clk(clk), .rst(rst), .enable(enable), .start(start), .bit_valid(bit_valid),
        .serial_in(serial_in), .msb_first(msb_first), .out_ready(out_ready),
        .parallel_out(parallel_out), .out_valid(out_valid), .busy(busy), .overrun(overrun),
        .frame_abort(frame_abort), .tmr_mismatch(tmr_mismatch)
    );

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: pulse counters and word delivery, sampled 2 time units after each rising edge.
    always begin
        @(posedge clk);
        #2;
        if (frame_abort === 1'b1) abort_seen++;
        if (tmr_mismatch === 1'b1) tmr_seen++;
        if (out_valid === 1'b1 && prev_ov !== 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_word actual=%h required=none", parallel_out);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("word", parallel_out, mon_exp);
            end
        end
        prev_ov = out_valid;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_pout"}, parallel_out, '0);
        chk({tag, "_out_valid"}, W'(out_valid), '0);
        chk({tag, "_busy"}, W'(busy), '0);
        chk({tag, "_overrun"}, W'(overrun), '0);
        chk({tag, "_abort"}, W'(frame_abort), '0);
        chk({tag, "_tmr"}, W'(tmr_mismatch), '0);
    endtask

    task automatic inject(input int bitpos);
        sbad  = dut.sreg_c2 ^ (W'(1) << bitpos);
        stbad = dut.state_c2 ^ 2'b10;
        force dut.sreg_c2 = sbad;
        force dut.state_c2 = stbad;
        #4;
        release dut.sreg_c2;
        release dut.state_c2;
        @(negedge clk);
    endtask

    task automatic begin_frame(input bit msb, input bit combine, input bit hs, input logic first_bit);
        start     = 1'b1;
        msb_first = msb;
        bit_valid = combine;
        serial_in = first_bit;
        out_ready = hs;
        step();
        start     = 1'b0;
        bit_valid = 1'b0;
        out_ready = 1'b0;
        msb_first = ~msb;
    endtask

    task automatic send_bits(input logic [W-1:0] w, input bit msb, input int first, input int last_excl,
                             input int gmin, input int gmax, input int inject_at, input int engap_at);
        for (int i = first; i < last_excl; i++) begin
            int idx;
            int g;
            idx = msb ? (W - 1 - i) : i;
            if (i == engap_at) begin
                enable = 1'b0;
                repeat (5) begin
                    bit_valid = 1'($urandom);
                    serial_in = 1'($urandom);
                    start     = 1'($urandom);
                    msb_first = 1'($urandom);
                    step();
                end
                enable = 1'b1;
                start  = 1'b0;
            end
            g = $urandom_range(gmax, gmin);
            repeat (g) begin
                bit_valid = 1'b0;
                serial_in = 1'($urandom);
                msb_first = 1'($urandom);
                step();
            end
            bit_valid = 1'b1;
            serial_in = w[idx];
            if (i == inject_at) inject($urandom_range(W - 1, 0));
            else step();
            bit_valid = 1'b0;
        end
    endtask

    task automatic frame(input logic [W-1:0] w, input bit msb, input bit combine, input bit hs,
                         input int gmin, input int gmax, input int inject_at, input int engap_at);
        exp_q.push_back(w);
        begin_frame(msb, combine, hs, w[msb ? W - 1 : 0]);
        send_bits(w, msb, combine ? 1 : 0, W, gmin, gmax, inject_at, engap_at);
        chk("out_valid_latency", W'(out_valid), W'(1));
        chk("busy_in_hold", W'(busy), '0);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("hs_out_valid", W'(out_valid), '0);
        chk("hs_busy_idle", W'(busy), '0);
    endtask

    initial begin
        logic [W-1:0] w;
        int           a0;
        int           t0;
        bit           in_hold;
        bit           hs;

        rst = 1'b1; enable = 1'b1; start = 1'b0; bit_valid = 1'b0;
        serial_in = 1'b0; msb_first = 1'b0; out_ready = 1'b0;
        step();
        step();
        chk_reset_outputs("reset");
        rst = 1'b0;

        // LSB first, back-to-back bits
        frame(64'h0123_4567_89AB_CDEF, 1'b0, 1'b0, 1'b0, 0, 0, -1, -1);
        chk("lsb_pout", parallel_out, 64'h0123_4567_89AB_CDEF);
        handshake();
        chk("no_overrun", W'(overrun), '0);

        // MSB first, first bit with start, bit every other cycle
        frame(64'h0123_4567_89AB_CDEF, 1'b1, 1'b1, 1'b0, 1, 1, -1, -1);
        chk("msb_pout", parallel_out, 64'h0123_4567_89AB_CDEF);
        handshake();

        // Input while held
        w = {$urandom, $urandom};
        frame(w, 1'($urandom), 1'b0, 1'b0, 0, 2, -1, -1);
        for (int c = 0; c < 10; c++) begin
            bit_valid = (c == 2 || c == 5 || c == 8);
            serial_in = 1'($urandom);
            step();
        end
        bit_valid = 1'b0;
        chk("overrun_set", W'(overrun), W'(1));
        chk("overrun_pout_kept", parallel_out, w);
        chk("overrun_valid_kept", W'(out_valid), W'(1));
        handshake();

        // Bits in IDLE without start are ignored
        repeat (3) begin
            bit_valid = 1'b1;
            serial_in = 1'($urandom);
            step();
        end
        bit_valid = 1'b0;
        chk("idle_bits_busy", W'(busy), '0);
        chk("idle_bits_valid", W'(out_valid), '0);

        // Restart after 20 bits
        a0 = abort_seen;
        chk("no_abort_yet", W'(a0), '0);
        w = {$urandom, $urandom};
        begin_frame(1'b0, 1'b0, 1'b0, 1'b0);
        send_bits(w, 1'b0, 0, 20, 0, 1, -1, -1);
        frame(64'hFFFF_0000_A5A5_5A5A, 1'b0, 1'b0, 1'b0, 0, 1, -1, -1);
        chk("abort_pulses", W'(abort_seen - a0), W'(1));
        chk("abort_pout", parallel_out, 64'hFFFF_0000_A5A5_5A5A);
        handshake();

        // Single-copy upset mid-frame
        t0 = tmr_seen;
        chk("no_tmr_yet", W'(t0), '0);
        frame({$urandom, $urandom}, 1'b1, 1'b0, 1'b0, 0, 2, 30, -1);
        chk("tmr_pulses", W'(tmr_seen - t0), W'(1));
        handshake();

        // Reset mid-frame, with enable low to show reset wins
        begin_frame(1'b0, 1'b0, 1'b0, 1'b0);
        send_bits({$urandom, $urandom}, 1'b0, 0, 30, 0, 1, -1, -1);
        rst = 1'b1;
        enable = 1'b0;
        step();
        rst = 1'b0;
        enable = 1'b1;
        chk_reset_outputs("midframe_reset");

        // Enable dropped for 5 cycles mid-frame
        frame({$urandom, $urandom}, 1'b0, 1'b0, 1'b0, 0, 1, -1, 20);
        // Handshake and new start in the same cycle
        frame({$urandom, $urandom}, 1'b1, 1'b1, 1'b1, 0, 2, -1, -1);
        chk("hs_start_no_overrun", W'(overrun), '0);

        in_hold = 1'b1;
        for (int k = 0; k < 8; k++) begin
            hs = 1'($urandom);
            if (in_hold && !hs) begin
                repeat ($urandom_range(3, 0)) step();
                handshake();
            end
            frame({$urandom, $urandom}, 1'($urandom), 1'($urandom), hs, 0, 3, -1,
                  ($urandom_range(1, 0) == 1) ? int'($urandom_range(W - 1, 2)) : -1);
        end
        handshake();
        repeat (3) step();

        chk("scoreboard_empty", W'(exp_q.size()), '0);
        chk("overrun_clear_since_reset", W'(overrun), '0);
        chk("abort_total", W'(abort_seen), W'(1));
        chk("tmr_total", W'(tmr_seen), W'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
